// File: rtl/sdu_uart_rx.sv
// sdu_uart_rx: serial debug unit receive front end.
// 8N1 UART receiver with 16x oversampling, start-bit glitch rejection,
// framing/overrun detection and a small valid/ready receive FIFO.
// Optional build macro SDU_RX_PARITY_EN: 8E1 framing plus a parity_err pulse.
module sdu_uart_rx #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        rxd,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic                        busy,
  output logic                        frame_err,
`ifdef SDU_RX_PARITY_EN
  output logic                        parity_err,
`endif
  output logic                        overrun
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t        state_q;
  logic [3:0]    tc_q;
  logic [2:0]    bi_q;
  logic [7:0]    shift_q;
  logic          busy_q, frame_err_q;
  logic          sync1_q, sync2_q, rxd_s;
  logic [DW-1:0] div_q;
  logic          tick, samp, push;
`ifdef SDU_RX_PARITY_EN
  logic          par_ok_q, parity_err_q;
`endif

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end
  assign rxd_s = sync2_q;

  // Oversample divider, held at zero in IDLE so ticks align to the start edge
  always_ff @(posedge clk) begin
    if (!rstn || state_q == S_IDLE) div_q <= '0;
    else if (tick)                  div_q <= '0;
    else                            div_q <= div_q + 1'b1;
  end
  assign tick = (state_q != S_IDLE) && (div_q == DW'(DIV - 1));
  assign samp = tick && (tc_q == 4'd15);

`ifdef SDU_RX_PARITY_EN
  assign push = (state_q == S_STOP) && samp && rxd_s && par_ok_q;
`else
  assign push = (state_q == S_STOP) && samp && rxd_s;
`endif

  // Receive FSM: start qualification, LSB-first shift, stop/break handling
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      tc_q         <= '0;
      bi_q         <= '0;
      shift_q      <= '0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef SDU_RX_PARITY_EN
      par_ok_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q  <= 1'b0;
`ifdef SDU_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (!rxd_s) begin
            state_q <= S_START;
            tc_q    <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (tick) begin
            tc_q <= tc_q + 1'b1;
            if (tc_q == 4'd7) begin
              if (rxd_s) begin
                // start bit did not survive to mid-bit: treat as noise
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_DATA;
                bi_q    <= '0;
                tc_q    <= '0;
              end
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            tc_q <= tc_q + 1'b1;
            if (tc_q == 4'd15) begin
              shift_q <= {rxd_s, shift_q[7:1]};
              bi_q    <= bi_q + 1'b1;
`ifdef SDU_RX_PARITY_EN
              if (bi_q == 3'd7) state_q <= S_PARITY;
`else
              if (bi_q == 3'd7) state_q <= S_STOP;
`endif
            end
          end
        end
`ifdef SDU_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            tc_q <= tc_q + 1'b1;
            if (tc_q == 4'd15) begin
              // even parity: data bits plus parity bit must XOR to zero
              par_ok_q     <= ~(^shift_q ^ rxd_s);
              parity_err_q <= ^shift_q ^ rxd_s;
              state_q      <= S_STOP;
            end
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            tc_q <= tc_q + 1'b1;
            if (tc_q == 4'd15) begin
              if (rxd_s) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= S_WAIT_HIGH;
              end
            end
          end
        end
        S_WAIT_HIGH: begin
          // line held low (break): wait for idle before hunting a new start
          if (rxd_s) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign frame_err = frame_err_q;
`ifdef SDU_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

  // ---------------- receive FIFO ----------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          overrun_q, full, pop, wr_en;

  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign rx_valid = (cnt_q != '0);
  assign pop      = rx_valid && rx_ready;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign wr_en    = push && (!full || pop);
  assign rx_data  = mem_q[rd_q];
  assign rx_count = cnt_q;
  assign overrun  = overrun_q;

  // Occupancy next-state
  always_comb begin
    cnt_d = cnt_q;
    if (wr_en && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !wr_en) cnt_d = cnt_q - 1'b1;
  end

  // FIFO storage, pointers and overrun pulse
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_q      <= '0;
      wr_q      <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q     <= cnt_d;
      overrun_q <= push && full && !pop;
      if (wr_en) begin
        mem_q[wr_q] <= shift_q;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_sdu_uart_rx.sv
// Testbench for sdu_uart_rx: frame-level serial driver, a negedge monitor
// collecting popped bytes and error pulses, and a queue-based FIFO model.
module tb_sdu_uart_rx;
  localparam int CLK_FREQ = 16000000;
  localparam int BAUD     = 1000000;
  localparam int DEPTH    = 4;
  localparam int CW       = $clog2(DEPTH) + 1;
`ifdef SDU_RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif
  typedef logic [7:0] bq_t [$];

  logic          clk = 1'b0, rstn = 1'b0, rxd = 1'b1, rx_ready = 1'b0;
  logic [7:0]    rx_data;
  logic          rx_valid, busy, frame_err, overrun;
  logic [CW-1:0] rx_count;
`ifdef SDU_RX_PARITY_EN
  logic          parity_err;
`endif

  sdu_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_count(rx_count), .busy(busy), .frame_err(frame_err),
`ifdef SDU_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int   n_vec = 0, n_err = 0;
  int   cyc_n = 0, n_rise = 0, rise_cyc = 0, n_ferr = 0, n_over = 0;
  int   f_start = 0, lat = NBITS * 16 + 11;
  logic vld_prev = 1'b0, busy_hold = 1'b0;
  bq_t  got;

  always @(posedge clk) cyc_n++;

  // Monitor, sampled mid-cycle: pops, valid rises, error pulses
  always @(negedge clk) begin
    if (rx_valid && !vld_prev) begin n_rise++; rise_cyc = cyc_n; end
    vld_prev = rx_valid;
    if (rstn && rx_valid && rx_ready) got.push_back(rx_data);
    if (frame_err) n_ferr++;
    if (overrun) n_over++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  function automatic bit q_eq(input bq_t a, input bq_t b);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  // One frame, 16 clk per bit. stop_low>0 holds the line low that long from
  // the stop bit on. rdy_at: -1 leave rx_ready alone, -2 random each cycle,
  // >=0 pulse rx_ready only during frame cycle rdy_at.
  task automatic send(input logic [7:0] b, input int stop_low, input int rdy_at);
    logic bits[$];
    int   total;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef SDU_RX_PARITY_EN
    bits.push_back(^b);
`endif
    total   = NBITS * 16 + stop_low + 16;
    f_start = cyc_n;
    for (int c = 0; c < total; c++) begin
      if (c < NBITS * 16) rxd = bits[c / 16];
      else if (c < NBITS * 16 + stop_low) rxd = 1'b0;
      else begin
        if (stop_low > 0 && c == NBITS * 16 + stop_low) busy_hold = busy;
        rxd = 1'b1;
      end
      if (rdy_at == -2)     rx_ready = 1'($urandom_range(0, 1));
      else if (rdy_at >= 0) rx_ready = (c == rdy_at);
      cyc();
    end
    if (rdy_at != -1) rx_ready = 1'b0;
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    repeat (DEPTH + 3) cyc();
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; rxd = 1'b1; rx_ready = 1'b0;
    repeat (3) cyc();
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b exp 0", rx_valid); end
    n_vec++; if (rx_count !== '0) begin n_err++; $display("FAIL rst_count: got %0d exp 0", rx_count); end
    n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h exp 00", rx_data); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rst_ferr: got %b exp 0", frame_err); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun: got %b exp 0", overrun); end
    rstn = 1'b1;
    repeat (4) cyc();
  endtask

  task automatic test_basic();
    bq_t exp_q;
    int  lat_m;
    got.delete(); n_rise = 0; n_ferr = 0;
    send(8'hA5, 0, -1);
    exp_q.push_back(8'hA5);
    lat_m = rise_cyc - f_start;
    n_vec++; if (n_rise !== 1) begin n_err++; $display("FAIL basic_rises: got %0d exp 1", n_rise); end
    n_vec++; if (rx_data !== 8'hA5) begin n_err++; $display("FAIL basic_data: got %h exp a5", rx_data); end
    n_vec++; if (rx_count !== CW'(1)) begin n_err++; $display("FAIL basic_count: got %0d exp 1", rx_count); end
    n_vec++; if (n_ferr !== 0) begin n_err++; $display("FAIL basic_ferr: got %0d exp 0", n_ferr); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy: got %b exp 0", busy); end
    // byte should land around mid stop bit plus synchronizer delay
    n_vec++;
    if (lat_m < NBITS * 16 + 9 || lat_m > NBITS * 16 + 13) begin
      n_err++; $display("FAIL basic_latency: got %0d exp %0d..%0d", lat_m, NBITS * 16 + 9, NBITS * 16 + 13);
    end else lat = lat_m;
    drain();
    n_vec++; if (!q_eq(got, exp_q)) begin n_err++; $display("FAIL basic_drain: got %p exp %p", got, exp_q); end
  endtask

  task automatic test_glitch();
    n_rise = 0; n_ferr = 0; n_over = 0;
    rxd = 1'b0;
    repeat (4) cyc();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_hi: got %b exp 1", busy); end
    rxd = 1'b1;
    repeat (10) cyc();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_lo: got %b exp 0", busy); end
    n_vec++; if (n_rise !== 0) begin n_err++; $display("FAIL glitch_byte: got %0d exp 0", n_rise); end
    n_vec++; if (n_ferr + n_over !== 0) begin n_err++; $display("FAIL glitch_err: got %0d exp 0", n_ferr + n_over); end
    repeat (20) cyc();
  endtask

  task automatic test_frame_err();
    bq_t exp_q;
    got.delete(); n_ferr = 0; n_rise = 0;
    send(8'h3C, 40, -1);
    n_vec++; if (busy_hold !== 1'b1) begin n_err++; $display("FAIL ferr_wait_high: got %b exp 1", busy_hold); end
    n_vec++; if (n_ferr !== 1) begin n_err++; $display("FAIL ferr_pulses: got %0d exp 1", n_ferr); end
    n_vec++; if (rx_count !== '0) begin n_err++; $display("FAIL ferr_count: got %0d exp 0", rx_count); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ferr_idle: got %b exp 0", busy); end
    send(8'h11, 0, -1);
    exp_q.push_back(8'h11);
    drain();
    n_vec++; if (!q_eq(got, exp_q)) begin n_err++; $display("FAIL ferr_next: got %p exp %p", got, exp_q); end
  endtask

  task automatic test_overrun();
    bq_t mdl;
    int  exp_over = 0;
    got.delete(); n_over = 0;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      send(8'(i), 0, -1);
      if (mdl.size() < DEPTH) mdl.push_back(8'(i)); else exp_over++;
      n_vec++; if (n_over !== exp_over) begin n_err++; $display("FAIL ovr_pulse_%0d: got %0d exp %0d", i, n_over, exp_over); end
    end
    n_vec++; if (rx_count !== CW'(mdl.size())) begin n_err++; $display("FAIL ovr_count: got %0d exp %0d", rx_count, mdl.size()); end
    drain();
    n_vec++; if (!q_eq(got, mdl)) begin n_err++; $display("FAIL ovr_drain: got %p exp %p", got, mdl); end
  endtask

  task automatic test_full_pop();
    bq_t mdl, out;
    got.delete(); n_over = 0;
    for (int i = 0; i < DEPTH; i++) begin
      send(8'(8'h70 + i), 0, -1);
      mdl.push_back(8'(8'h70 + i));
    end
    // rx_ready high only in the cycle the 0x77 stop bit is accepted
    send(8'h77, 0, lat - 1);
    out.push_back(mdl.pop_front());
    mdl.push_back(8'h77);
    n_vec++; if (n_over !== 0) begin n_err++; $display("FAIL fullpop_overrun: got %0d exp 0", n_over); end
    n_vec++; if (rx_count !== CW'(DEPTH)) begin n_err++; $display("FAIL fullpop_count: got %0d exp %0d", rx_count, DEPTH); end
    n_vec++; if (!q_eq(got, out)) begin n_err++; $display("FAIL fullpop_popped: got %p exp %p", got, out); end
    drain();
    foreach (mdl[i]) out.push_back(mdl[i]);
    n_vec++; if (!q_eq(got, out)) begin n_err++; $display("FAIL fullpop_order: got %p exp %p", got, out); end
  endtask

  task automatic test_mid_reset();
    bq_t exp_q;
    logic [7:0] b = 8'hFF;
    send(8'h42, 0, -1);
    n_vec++; if (rx_count !== CW'(1)) begin n_err++; $display("FAIL mrst_pre_count: got %0d exp 1", rx_count); end
    for (int c = 0; c < 60; c++) begin
      rxd = (c < 16) ? 1'b0 : b[(c / 16) - 1];
      cyc();
    end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mrst_in_frame: got %b exp 1", busy); end
    rstn = 1'b0; rxd = 1'b1;
    cyc();
    rstn = 1'b1;
    n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL mrst_valid: got %b exp 0", rx_valid); end
    n_vec++; if (rx_count !== '0) begin n_err++; $display("FAIL mrst_count: got %0d exp 0", rx_count); end
    n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL mrst_data: got %h exp 00", rx_data); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mrst_busy: got %b exp 0", busy); end
    repeat (40) cyc();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mrst_no_restart: got %b exp 0", busy); end
    got.delete();
    send(8'h5A, 0, -1);
    exp_q.push_back(8'h5A);
    drain();
    n_vec++; if (!q_eq(got, exp_q)) begin n_err++; $display("FAIL mrst_next: got %p exp %p", got, exp_q); end
  endtask

  task automatic test_random();
    bq_t exp_q;
    got.delete(); n_ferr = 0; n_over = 0;
    for (int k = 0; k < 10; k++) begin
      logic [7:0] b = 8'($urandom);
      repeat ($urandom_range(0, 20)) cyc();
      send(b, 0, -2);
      exp_q.push_back(b);
    end
    drain();
    n_vec++; if (!q_eq(got, exp_q)) begin n_err++; $display("FAIL rand_bytes: got %p exp %p", got, exp_q); end
    n_vec++; if (n_ferr + n_over !== 0) begin n_err++; $display("FAIL rand_errs: got %0d exp 0", n_ferr + n_over); end
    n_vec++; if (rx_count !== '0) begin n_err++; $display("FAIL rand_count: got %0d exp 0", rx_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_full_pop();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
